// File: rtl/regs_write_arbiter_if.sv
// regs_write_arbiter_if: requester-side handshake and register-file write bus for the write arbiter.
interface regs_write_arbiter_if;
    logic [3:0] req;
    logic [2:0] wreg0, wreg1, wreg2, wreg3;
    logic       wisReg0, wisReg1, wisReg2, wisReg3;
    logic       hold;
    logic [3:0] ack;
    logic       isWrite;
    logic [2:0] writeReg;
    logic       isRegW;
    logic [2:0] dataSel;
    logic       err;
    logic       busy;
    modport master (
        output req, wreg0, wreg1, wreg2, wreg3, wisReg0, wisReg1, wisReg2, wisReg3, hold,
        input  ack, isWrite, writeReg, isRegW, dataSel, err, busy
    );
    modport slave (
        input  req, wreg0, wreg1, wreg2, wreg3, wisReg0, wisReg1, wisReg2, wisReg3, hold,
        output ack, isWrite, writeReg, isRegW, dataSel, err, busy
    );
endinterface

// File: rtl/regs_write_arbiter.sv
// regs_write_arbiter: round-robin arbiter granting one register-file write per cycle among four requesters.
module regs_write_arbiter (
    input logic                 CLK,
    input logic                 RST_N,
    regs_write_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state;
    logic [1:0] ptr;
    logic [3:0] eligible;
    logic [1:0] w;
    logic       found;
    logic [2:0] wregW;
    logic       wisRegW;
    logic       legal;
    // ack is only nonzero in GRANT; masking it stops a 1-cycle req tail from re-winning
    assign eligible = (state == GRANT) ? bus.req & ~bus.ack : bus.req;
    assign bus.busy = |(bus.req & ~bus.ack);
    always_comb begin
        w = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && eligible[ptr + 2'(k)]) begin
                w = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end
    assign wregW   = (w == 2'd0) ? bus.wreg0 : (w == 2'd1) ? bus.wreg1 : (w == 2'd2) ? bus.wreg2 : bus.wreg3;
    assign wisRegW = (w == 2'd0) ? bus.wisReg0 : (w == 2'd1) ? bus.wisReg1 : (w == 2'd2) ? bus.wisReg2 : bus.wisReg3;
    assign legal   = wisRegW || (wregW <= 3'd5);
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= IDLE;
            ptr          <= 2'd0;
            bus.ack      <= 4'd0;
            bus.isWrite  <= 1'b0;
            bus.writeReg <= 3'd0;
            bus.isRegW   <= 1'b0;
            bus.dataSel  <= 3'd0;
            bus.err      <= 1'b0;
        end else if (found && !bus.hold) begin
            state        <= GRANT;
            ptr          <= w + 2'd1;
            bus.ack      <= 4'b0001 << w;
            bus.isWrite  <= legal;
            bus.err      <= !legal;
            bus.writeReg <= legal ? wregW : 3'd0;
            bus.isRegW   <= legal && wisRegW;
            bus.dataSel  <= legal ? {1'b0, w} + 3'd1 : 3'd0;
        end else begin
            state        <= IDLE;
            bus.ack      <= 4'd0;
            bus.isWrite  <= 1'b0;
            bus.writeReg <= 3'd0;
            bus.isRegW   <= 1'b0;
            bus.dataSel  <= 3'd0;
            bus.err      <= 1'b0;
        end
    end
endmodule

// File: doc/regs_write_arbiter.md
REGS_WRITE_ARBITER -- requirements
Module: regs_write_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port req, input, 4 bits: req[i]=1 means requester i wants one register-file write.
REQ-004 SHALL have ports wreg0..wreg3, input, 3 bits each: target register index of requester i.
REQ-005 SHALL have ports wisReg0..wisReg3, input, 1 bit each: target class of requester i; 1 = regular bank, 0 = accumulator bank.
REQ-006 SHALL have port hold, input, 1 bit: datapath stall; while 1, no new grant is issued.
REQ-007 SHALL have port ack, output, 4 bits: one-hot pulse; requester i's request was accepted.
REQ-008 SHALL have port isWrite, output, 1 bit: register-file write enable.
REQ-009 SHALL have port writeReg, output, 3 bits: register-file write index.
REQ-010 SHALL have port isRegW, output, 1 bit: write targets the regular bank.
REQ-011 SHALL have port dataSel, output, 3 bits: write-data mux select; 0 = zero source, i+1 = requester i.
REQ-012 SHALL have port err, output, 1 bit: pulse; the accepted request targeted an illegal register.
REQ-013 SHALL have port busy, output, 1 bit: combinational; 1 when any req bit is set that is not acked this cycle.

Function
REQ-014 SHALL keep a 2-bit round-robin pointer ptr naming the highest-priority requester; priority descends ptr, ptr+1, ptr+2, ptr+3, mod 4.
REQ-015 SHALL form each cycle: eligible = req & ~ack; then select the winner w as the first eligible requester in priority order.
- Masking with ack is what makes a 1-cycle req tail after an ack harmless.
REQ-016 SHALL issue no grant on an edge where hold=1 or eligible=0; on that edge, all of ack, isWrite, err, dataSel, writeReg and isRegW go to 0.
REQ-017 SHALL register all outputs except busy, giving a latency of 1 cycle.
- When req is sampled at edge N with a winner w, the outputs are valid from edge N to edge N+1.
- In that window: ack = 1<<w, writeReg = wreg_w, isRegW = wisReg_w, dataSel = w+1.
REQ-018 SHALL treat a target as legal when wisReg_w=1 (index bits [1:0] are used), or when wisReg_w=0 and wreg_w <= 5.
REQ-019 SHALL, for a legal target, drive isWrite=1 and err=0 in the grant window.
REQ-020 SHALL, for an illegal target (accumulator index 6 or 7), drive isWrite=0, err=1, dataSel=0, writeReg=0 and ack=1<<w.
- The request is consumed and dropped, never retried.
REQ-021 SHALL, on every grant (legal or illegal), set ptr to w+1 mod 4; ptr is unchanged on cycles with no grant.
REQ-022 Handshake rules:
- The requester holds req, wreg and wisReg stable until it samples ack=1.
- After sampling ack, it drops req, or keeps req high to post a new request.
- A requester may win at most every other cycle; with two or more requesters active, the port issues one write per cycle.
REQ-023 SHALL NOT withdraw a grant once issued: hold rising during a grant window does not cancel that window's outputs; it only blocks the next grant.
REQ-024 SHALL define state as GRANT when ack != 0 and IDLE otherwise.
- IDLE -> GRANT when eligible != 0 and hold = 0.
- GRANT -> GRANT under the same condition; otherwise GRANT -> IDLE.
REQ-025 SHALL guarantee that a continuously requesting requester is granted within 4 grant cycles (no starvation).

Reset
REQ-026 SHALL, on an edge with RST_N=0, set ptr=0, ack=0, isWrite=0, writeReg=0, isRegW=0, dataSel=0 and err=0, regardless of req or hold.
REQ-027 SHALL, when RST_N=0 arrives during a grant window, clear that window at the same edge; the pending request is not acked and must be re-presented.
REQ-028 SHALL allow the first grant at the first edge with RST_N=1, with requester 0 at top priority.

Verification
REQ-029 Single request: after reset, req=0001, wreg0=3, wisReg0=0 -> next cycle isWrite=1, writeReg=3, isRegW=0, dataSel=1, ack=0001, ptr becomes 1.
REQ-030 Round-robin: req=1111 held for 4 grants from ptr=0 -> ack sequence 0001, 0010, 0100, 1000; then 0001 again.
REQ-031 Illegal target: req=0100, wreg2=7, wisReg2=0 -> ack=0100, err=1, isWrite=0, dataSel=0; regular target wreg2=7, wisReg2=1 -> isWrite=1, writeReg=7, isRegW=1.
REQ-032 Hold: req=0011 with hold=1 for 3 cycles -> ack=0, isWrite=0, busy=1 throughout; hold falls -> grant to requester 0 on the next edge.
REQ-033 Back-to-back: req=0001 held continuously -> ack alternates 0001, 0000, 0001.
REQ-034 Reset mid-grant: RST_N=0 during a window with ack=0010 -> all outputs 0 at that edge, ptr=0; RST_N=1 with req=0010 still high -> ack=0010 one cycle later.
